axis_frame_packer: RTL and testbench

- Upstream neighbour of the window stage in the FFT_CORE datapath.
- Accepts a serial AXI-Stream of complex samples, one per beat, with a start-of-frame (SOF) marker.
- Packs BUS_NUM consecutive samples into one wide beat and asserts TLAST on the last beat of every FFT_SIZE-sample frame, producing the packet format the window and FFT stages consume.
- Provides frame-synchronisation control and status: enable, frame counter, SOF error pulse.

---
 rtl/axis_frame_packer.sv | 157 +++++++++++++++
 tb/tb_axis_frame_packer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_packer.sv
// axis_frame_packer: serial complex-sample AXI-Stream to BUS_NUM-wide beats.
// Waits for a start-of-frame marker, then packs BUS_NUM consecutive samples
// per output beat and flags the last beat of each FFT_SIZE-sample frame.
// A sample is {re, im}, each DATA_W bits signed, re in the upper half.
module axis_frame_packer #(
   parameter int FFT_SIZE = 8192,
   parameter int BUS_NUM  = 2,
   parameter int DATA_W   = 16,
   parameter int BEAT_AW  = $clog2(FFT_SIZE / BUS_NUM),
   parameter int LANE_AW  = $clog2(BUS_NUM)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                en,
   input  logic                                in_tvalid,
   output logic                                in_tready,
   input  logic                                in_tuser,
   input  logic [2*DATA_W-1:0]                 in_tdata,
   output logic                                out_tvalid,
   input  logic                                out_tready,
   output logic                                out_tlast,
   output logic [BUS_NUM-1:0][2*DATA_W-1:0]    out_tdata,
   output logic [1:0]                          state_o,
   output logic [15:0]                         frame_cnt,
   output logic                                sof_err
);

   localparam int SMP_W = 2 * DATA_W;
   localparam logic [LANE_AW-1:0] LANE_LAST = LANE_AW'(BUS_NUM - 1);
   localparam logic [BEAT_AW-1:0] BEAT_LAST = BEAT_AW'(FFT_SIZE / BUS_NUM - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_PACK = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic [LANE_AW-1:0]              lane_q, lane_d;
   logic [BEAT_AW-1:0]              beat_q, beat_d;
   logic [BUS_NUM-2:0][SMP_W-1:0]   gather_q, gather_d;
   logic [BUS_NUM-1:0][SMP_W-1:0]   out_data_q, out_data_d;
   logic                            out_valid_q, out_valid_d;
   logic                            out_last_q, out_last_d;
   logic [15:0]                     frame_cnt_q, frame_cnt_d;
   logic                            sof_err_q, sof_err_d;

   logic lane_full;
   logic sof_slot;
   logic hs;
   logic pop;

   assign lane_full = (lane_q == LANE_LAST);
   // Sample 0 of a frame: first lane of the first beat.
   assign sof_slot  = (lane_q == '0) && (beat_q == '0);
   assign hs        = in_tvalid && in_tready;
   assign pop       = out_valid_q && out_tready;

   // Input ready: the closing sample of a beat stalls while the output slot is still occupied.
   always_comb begin
      in_tready = 1'b0;
      case (state_q)
         ST_SYNC: in_tready = 1'b1;
         ST_PACK: in_tready = !(lane_full && out_valid_q && !out_tready);
         default: in_tready = 1'b0;
      endcase
   end

   // Next-state: frame sync, lane gathering, beat emission and status.
   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      beat_d      = beat_q;
      gather_d    = gather_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_valid_d = pop ? 1'b0 : out_valid_q;
      frame_cnt_d = frame_cnt_q;
      sof_err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            // Dropping en wins over a simultaneous SOF; non-SOF samples are discarded.
            if (!en) begin
               state_d = ST_IDLE;
            end else if (hs && in_tuser) begin
               gather_d[0] = in_tdata;
               lane_d      = LANE_AW'(1);
               beat_d      = '0;
               state_d     = ST_PACK;
            end
         end
         ST_PACK: begin
            if (hs) begin
               // SOF must be present exactly on sample 0; either violation is only flagged.
               sof_err_d = in_tuser ^ sof_slot;
               if (lane_full) begin
                  for (int i = 0; i < BUS_NUM - 1; i++) begin
                     out_data_d[i] = gather_q[i];
                  end
                  out_data_d[BUS_NUM-1] = in_tdata;
                  out_valid_d = 1'b1;
                  out_last_d  = (beat_q == BEAT_LAST);
                  lane_d      = '0;
                  beat_d      = beat_q + BEAT_AW'(1);
                  if (beat_q == BEAT_LAST) begin
                     frame_cnt_d = frame_cnt_q + 16'd1;
                     if (!en) state_d = ST_IDLE;
                  end
               end else begin
                  for (int i = 0; i < BUS_NUM - 1; i++) begin
                     if (lane_q == LANE_AW'(i)) gather_d[i] = in_tdata;
                  end
                  lane_d = lane_q + LANE_AW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         lane_q      <= '0;
         beat_q      <= '0;
         gather_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         frame_cnt_q <= '0;
         sof_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         beat_q      <= beat_d;
         gather_q    <= gather_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         frame_cnt_q <= frame_cnt_d;
         sof_err_q   <= sof_err_d;
      end
   end

   assign out_tvalid = out_valid_q;
   assign out_tlast  = out_last_q;
   assign out_tdata  = out_data_q;
   assign state_o    = state_q;
   assign frame_cnt  = frame_cnt_q;
   assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_axis_frame_packer.sv
// Testbench for axis_frame_packer with FFT_SIZE=8, BUS_NUM=2.
// A frame-level model predicts every output each cycle; directed scenarios
// add literal expectations, followed by a randomized multi-frame run.
module tb_axis_frame_packer;

   localparam int FFT_SIZE = 8;
   localparam int BUS_NUM  = 2;
   localparam int DATA_W   = 16;
   localparam int SMP_W    = 2 * DATA_W;
   localparam int BEATS    = FFT_SIZE / BUS_NUM;

   logic                              clk = 1'b0;
   logic                              rst_n = 1'b0;
   logic                              en = 1'b0;
   logic                              in_tvalid = 1'b0;
   logic                              in_tuser = 1'b0;
   logic [SMP_W-1:0]                  in_tdata = '0;
   logic                              out_tready = 1'b0;
   logic                              in_tready;
   logic                              out_tvalid;
   logic                              out_tlast;
   logic [BUS_NUM-1:0][SMP_W-1:0]     out_tdata;
   logic [1:0]                        state_o;
   logic [15:0]                       frame_cnt;
   logic                              sof_err;

   axis_frame_packer #(.FFT_SIZE(FFT_SIZE), .BUS_NUM(BUS_NUM), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tuser(in_tuser), .in_tdata(in_tdata),
      .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast), .out_tdata(out_tdata),
      .state_o(state_o), .frame_cnt(frame_cnt), .sof_err(sof_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [SMP_W-1:0] mk(input int v);
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
      re = DATA_W'(v);
      im = -re;
      return {re, im};
   endfunction

   // ---------------- stimulus source ----------------
   typedef struct packed {
      logic             sof;
      logic [SMP_W-1:0] d;
   } src_t;
   src_t src_q[$];
   int   pvalid = 100;
   int   pready = 100;
   logic stall  = 1'b0;

   task automatic push(input logic [SMP_W-1:0] d, input logic sof);
      src_t s;
      s.d = d;
      s.sof = sof;
      src_q.push_back(s);
   endtask

   task automatic push_frame(input int base, input int sof_mask);
      for (int i = 0; i < FFT_SIZE; i++) push(mk(base + i), sof_mask[i]);
   endtask

   initial begin : driver
      logic take;
      forever begin
         @(negedge clk);
         take = in_tvalid && in_tready;
         @(posedge clk);
         #1;
         if (take && src_q.size() > 0) void'(src_q.pop_front());
         if (src_q.size() == 0) in_tvalid = 1'b0;
         else if (!(in_tvalid && !take)) in_tvalid = ($urandom_range(0, 99) < pvalid);
         if (in_tvalid) begin
            in_tdata = src_q[0].d;
            in_tuser = src_q[0].sof;
         end else begin
            in_tdata = $urandom;
            in_tuser = $urandom_range(0, 1) == 1;
         end
         out_tready = stall ? 1'b0 : ($urandom_range(0, 99) < pready);
      end
   end

   // ---------------- behavioural model ----------------
   int                            m_mode  = 0;   // 0 idle, 1 waiting for SOF, 2 packing
   int                            m_pos   = 0;   // sample index inside the current frame
   logic [SMP_W-1:0]              m_gq[$];       // samples collected for the pending beat
   logic                          m_ov    = 1'b0;
   logic                          m_olast = 1'b0;
   logic [BUS_NUM-1:0][SMP_W-1:0] m_od    = '0;
   logic [15:0]                   m_fcnt  = '0;
   logic                          m_sof   = 1'b0;
   logic                          force_req = 1'b0;

   function automatic logic m_rdy();
      if (m_mode == 2) return !(m_gq.size() == BUS_NUM - 1 && m_ov && !out_tready);
      return m_mode == 1;
   endfunction

   initial begin : model
      logic hs, pop, load, nsof;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_mode = 0; m_pos = 0; m_gq.delete();
            m_ov = 1'b0; m_olast = 1'b0; m_od = '0; m_fcnt = '0; m_sof = 1'b0;
         end else begin
            hs = in_tvalid && m_rdy();
            pop = m_ov && out_tready;
            load = 1'b0;
            nsof = 1'b0;
            if (m_mode == 0) begin
               if (en) m_mode = 1;
            end else if (m_mode == 1) begin
               if (!en) m_mode = 0;
               else if (hs && in_tuser) begin
                  m_gq.delete();
                  m_gq.push_back(in_tdata);
                  m_pos = 1;
                  m_mode = 2;
               end
            end else if (hs) begin
               nsof = (in_tuser != (m_pos == 0));
               m_gq.push_back(in_tdata);
               m_pos++;
               if (m_gq.size() == BUS_NUM) begin
                  for (int i = 0; i < BUS_NUM; i++) m_od[i] = m_gq[i];
                  m_olast = (m_pos == FFT_SIZE);
                  load = 1'b1;
                  m_gq.delete();
               end
               if (m_pos == FFT_SIZE) begin
                  m_pos = 0;
                  m_fcnt = m_fcnt + 16'd1;
                  if (!en) m_mode = 0;
               end
            end
            if (load) m_ov = 1'b1;
            else if (pop) m_ov = 1'b0;
            m_sof = nsof;
            if (force_req) m_fcnt = 16'hFFFF;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin : compare
      forever begin
         @(negedge clk);
         check("in_tready",  80'(in_tready),  80'(m_rdy()));
         check("out_tvalid", 80'(out_tvalid), 80'(m_ov));
         check("out_tdata",  80'(out_tdata),  80'(m_od));
         check("out_tlast",  80'(out_tlast),  80'(m_olast));
         check("state_o",    80'(state_o),    80'(m_mode));
         check("frame_cnt",  80'(frame_cnt),  80'(m_fcnt));
         check("sof_err",    80'(sof_err),    80'(m_sof));
      end
   end

   // ---------------- monitor ----------------
   logic [64:0] log_q[$];
   int cyc = 0, acc_cnt = 0, hs1_cyc = -1, fv_cyc = -1, sof_cnt = 0, sof_run = 0, sof_max = 0;

   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (out_tvalid && out_tready) log_q.push_back({out_tlast, out_tdata});
         if (in_tvalid && in_tready) begin
            acc_cnt++;
            if (in_tdata == mk(1) && hs1_cyc < 0) hs1_cyc = cyc;
         end
         if (out_tvalid && fv_cyc < 0) fv_cyc = cyc;
         if (sof_err) begin
            sof_cnt++;
            sof_run++;
            if (sof_run > sof_max) sof_max = sof_run;
         end else sof_run = 0;
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   // ---------------- helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_mon();
      log_q.delete();
      acc_cnt = 0; hs1_cyc = -1; fv_cyc = -1; sof_cnt = 0; sof_max = 0;
   endtask

   task automatic wait_log(input int n, input string nm);
      for (int i = 0; i < 2000 && log_q.size() < n; i++) tick(1);
      check(nm, 80'(log_q.size()), 80'(n));
   endtask

   task automatic wait_state(input logic [1:0] s, input string nm);
      for (int i = 0; i < 200 && state_o != s; i++) tick(1);
      check(nm, 80'(state_o), 80'(s));
   endtask

   task automatic wait_acc(input int n, input string nm);
      for (int i = 0; i < 200 && acc_cnt < n; i++) tick(1);
      check(nm, 80'(acc_cnt >= n), 80'(1));
   endtask

   task automatic drain(input string nm);
      en = 1'b0;
      for (int i = 0; i < 200 && (state_o != 2'd0 || out_tvalid); i++) tick(1);
      check(nm, 80'({state_o, out_tvalid}), 80'(0));
      src_q.delete();
      tick(2);
   endtask

   // Beat k of a ramp frame starting at base: {tlast, lane1, lane0}.
   function automatic logic [64:0] ramp_beat(input int base, input int k);
      return {k == BEATS - 1, mk(base + 2 * k + 1), mk(base + 2 * k)};
   endfunction

   // ---------------- scenarios ----------------
   initial begin : tests
      logic bp_ready_low;
      tick(3);
      check("rst_in_tready", 80'(in_tready), 80'(0));
      check("rst_out_tvalid", 80'(out_tvalid), 80'(0));
      check("rst_out_tdata", 80'(out_tdata), 80'(0));
      check("rst_state", 80'(state_o), 80'(0));
      check("rst_frame_cnt", 80'(frame_cnt), 80'(0));
      rst_n = 1'b1;
      tick(2);

      // basic frame, en dropped during beat 2
      clear_mon();
      push_frame(0, 1);
      en = 1'b1;
      wait_acc(3, "basic_accept");
      en = 1'b0;
      wait_log(BEATS, "basic_beats");
      tick(2);
      for (int k = 0; k < BEATS; k++) check($sformatf("basic_beat%0d", k), 80'(log_q[k]), 80'(ramp_beat(0, k)));
      check("basic_latency", 80'(fv_cyc - hs1_cyc), 80'(1));
      check("basic_frame_cnt", 80'(frame_cnt), 80'(1));
      check("stop_state", 80'(state_o), 80'(0));
      check("stop_in_tready", 80'(in_tready), 80'(0));
      drain("basic_drain");

      // sync discard
      clear_mon();
      for (int i = 0; i < 3; i++) push(mk(100 + i), 1'b0);
      push_frame(10, 1);
      en = 1'b1;
      wait_state(2'd2, "sync_enter_pack");
      en = 1'b0;
      wait_log(BEATS, "sync_beats");
      check("sync_first_beat", 80'(log_q[0]), 80'({1'b0, mk(11), mk(10)}));
      check("sync_last_beat", 80'(log_q[BEATS-1]), 80'({1'b1, mk(17), mk(16)}));
      check("sync_no_sof_err", 80'(sof_cnt), 80'(0));
      check("sync_frame_cnt", 80'(frame_cnt), 80'(2));
      drain("sync_drain");

      // backpressure
      clear_mon();
      stall = 1'b1;
      tick(2);
      push_frame(0, 1);
      en = 1'b1;
      for (int i = 0; i < 100 && !out_tvalid; i++) tick(1);
      en = 1'b0;
      bp_ready_low = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_data", 80'({out_tvalid, out_tdata}), 80'({1'b1, mk(1), mk(0)}));
         if (!in_tready) bp_ready_low = 1'b1;
         tick(1);
      end
      check("bp_ready_low", 80'(bp_ready_low), 80'(1));
      stall = 1'b0;
      wait_log(BEATS, "bp_beats");
      for (int k = 0; k < BEATS; k++) check($sformatf("bp_beat%0d", k), 80'(log_q[k]), 80'(ramp_beat(0, k)));
      check("bp_frame_cnt", 80'(frame_cnt), 80'(3));
      drain("bp_drain");

      // misplaced SOF, then a frame lacking SOF
      clear_mon();
      push_frame(0, 'b1001);
      push_frame(20, 0);
      en = 1'b1;
      wait_log(BEATS, "msof_frame_a");
      en = 1'b0;
      wait_log(2 * BEATS, "msof_frame_b");
      check("msof_pulses", 80'(sof_cnt), 80'(2));
      check("msof_pulse_len", 80'(sof_max), 80'(1));
      check("msof_tlast_a", 80'(log_q[BEATS-1]), 80'(ramp_beat(0, BEATS - 1)));
      check("msof_b_first", 80'(log_q[BEATS]), 80'(ramp_beat(20, 0)));
      check("msof_tlast_b", 80'(log_q[2*BEATS-1]), 80'(ramp_beat(20, BEATS - 1)));
      check("msof_frame_cnt", 80'(frame_cnt), 80'(5));
      drain("msof_drain");

      // reset mid-frame
      clear_mon();
      push_frame(0, 1);
      en = 1'b1;
      wait_acc(3, "rst_accept");
      rst_n = 1'b0;
      #1;
      check("arst_out_tvalid", 80'(out_tvalid), 80'(0));
      check("arst_out_tdata", 80'(out_tdata), 80'(0));
      check("arst_state", 80'(state_o), 80'(0));
      check("arst_in_tready", 80'(in_tready), 80'(0));
      check("arst_frame_cnt", 80'(frame_cnt), 80'(0));
      src_q.delete();
      en = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);

      // frame counter wrap
      @(negedge clk);
      #1;
      force dut.frame_cnt_q = 16'hFFFF;
      force_req = 1'b1;
      @(posedge clk);
      #2;
      release dut.frame_cnt_q;
      force_req = 1'b0;
      tick(1);
      check("wrap_preset", 80'(frame_cnt), 80'(16'hFFFF));
      clear_mon();
      push_frame(0, 1);
      en = 1'b1;
      wait_state(2'd2, "wrap_pack");
      en = 1'b0;
      wait_log(BEATS, "wrap_beats");
      tick(1);
      check("wrap_frame_cnt", 80'(frame_cnt), 80'(0));
      drain("wrap_drain");

      // randomized contiguous frames with stalls and occasional SOF faults
      clear_mon();
      pvalid = 60;
      pready = 60;
      for (int i = 0; i < 2; i++) push($urandom, 1'b0);
      for (int f = 0; f < 12; f++) begin
         for (int i = 0; i < FFT_SIZE; i++) begin
            logic sof;
            sof = (i == 0);
            if ($urandom_range(0, 9) == 0) sof = !sof;
            if (f == 0 && i == 0) sof = 1'b1;
            push($urandom, sof);
         end
      end
      en = 1'b1;
      for (int i = 0; i < 4000 && src_q.size() >= FFT_SIZE / 2; i++) tick(1);
      en = 1'b0;
      pready = 100;
      wait_log(12 * BEATS, "rand_beats");
      drain("rand_drain");
      check("rand_frame_cnt", 80'(frame_cnt), 80'(12));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
